// File: rtl/tpu_pkg.sv
// Shared definitions for the weight-fetch path: store geometry, tile limits,
// controller state encoding and the tile range check.
package tpu_pkg;

  localparam int ADDR_W    = 13;
  localparam int MEM_DEPTH = 32;
  localparam int ARRAY_DIM = 4;
  localparam int MAX_ROWS  = 4;

  // Widened constants for the range check, which is done at ADDR_W+3 bits
  // so base + rows*ARRAY_DIM can never wrap.
  localparam logic [ADDR_W+2:0] DIM_EXT   = (ADDR_W+3)'(ARRAY_DIM);
  localparam logic [ADDR_W+2:0] DEPTH_EXT = (ADDR_W+3)'(MEM_DEPTH);
  localparam logic [2:0]        MAX_ROWS_W = 3'(MAX_ROWS);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(ARRAY_DIM);
  localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } wfc_state_t;

  // True when a tile of 'rows' rows starting at 'base' lies inside the store.
  function automatic logic tile_fits(input logic [ADDR_W-1:0] base,
                                     input logic [2:0]        rows);
    logic [ADDR_W+2:0] end_addr;
    end_addr = {3'd0, base} + ({{ADDR_W{1'b0}}, rows} * DIM_EXT);
    return (end_addr <= DEPTH_EXT);
  endfunction

endpackage

// File: rtl/weight_fetch_ctrl.sv
// Weight-fetch controller: sequences row reads from the weight store into the
// systolic array and lends the store's write port to the host while idle.
module weight_fetch_ctrl
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [7:0]        host_wr_data,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] fetch_base,
  input  logic [2:0]        fetch_rows,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic              fetch_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              array_load_en,
  output logic [1:0]        array_load_row
);

  wfc_state_t        state;
  wfc_state_t        next_state;
  logic [1:0]        row_cnt;
  logic [2:0]        rows_cap;
  logic [ADDR_W-1:0] raddr_q;
  logic              load_en_q;
  logic [1:0]        load_row_q;
  logic              err_q;
  logic              zero_done_q;
  logic              accept;
  logic              zero_cmd;
  logic              bad_cmd;
  logic              last_row;
  logic              host_xfer;

  // Classify a command strobe seen in IDLE: accept, empty, or reject.
  always_comb begin
    accept   = 1'b0;
    zero_cmd = 1'b0;
    bad_cmd  = 1'b0;
    if ((state == IDLE) && fetch_start) begin
      if (fetch_rows == 3'd0) begin
        zero_cmd = 1'b1;
      end else if ((fetch_rows > MAX_ROWS_W) || !tile_fits(fetch_base, fetch_rows)) begin
        bad_cmd = 1'b1;
      end else begin
        accept = 1'b1;
      end
    end else begin
      accept = 1'b0;
    end
  end

  assign last_row = ({1'b0, row_cnt} == (rows_cap - 3'd1));

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: one ISSUE cycle per row, then a single DRAIN cycle
  // while the last row's data comes back from the store.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = accept ? ISSUE : IDLE;
      ISSUE:   next_state = last_row ? DRAIN : ISSUE;
      DRAIN:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Row counter, read address and the one-cycle-delayed load strobe that
  // lines up with the store's read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt     <= 2'd0;
      rows_cap    <= 3'd0;
      raddr_q     <= '0;
      load_en_q   <= 1'b0;
      load_row_q  <= 2'd0;
      err_q       <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      if (accept) begin
        rows_cap <= fetch_rows;
        row_cnt  <= 2'd0;
        raddr_q  <= fetch_base;
      end else if ((state == ISSUE) && !last_row) begin
        row_cnt <= row_cnt + 2'd1;
        raddr_q <= raddr_q + ADDR_STEP;
      end
      load_en_q   <= (state == ISSUE);
      load_row_q  <= row_cnt;
      err_q       <= bad_cmd;
      zero_done_q <= zero_cmd;
    end
  end

  assign host_xfer = host_wr_valid && host_wr_ready;

  // Output decode; host writes pass straight through to the store when idle,
  // and out-of-range host writes are silently dropped.
  always_comb begin
    fetch_busy     = (state != IDLE);
    fetch_done     = (state == DRAIN) || zero_done_q;
    fetch_err      = err_q;
    host_wr_ready  = (state == IDLE) && !fetch_start;
    mem_we         = host_xfer && (host_wr_addr < DEPTH_ADDR) && !reset;
    mem_waddr      = '0;
    mem_wdata      = 8'd0;
    mem_raddr      = raddr_q;
    array_load_en  = load_en_q;
    array_load_row = load_row_q;
    if (mem_we) begin
      mem_waddr = host_wr_addr;
      mem_wdata = host_wr_data;
    end else begin
      mem_waddr = '0;
      mem_wdata = 8'd0;
    end
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: timing-rule reference model,
// vector tables, directed corner sequences and randomized traffic.
module tb_weight_fetch_ctrl;
  import tpu_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [7:0]        host_wr_data;
  logic              fetch_start;
  logic [ADDR_W-1:0] fetch_base;
  logic [2:0]        fetch_rows;
  logic              fetch_busy;
  logic              fetch_done;
  logic              fetch_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic              array_load_en;
  logic [1:0]        array_load_row;

  weight_fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .fetch_start(fetch_start), .fetch_base(fetch_base), .fetch_rows(fetch_rows),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done), .fetch_err(fetch_err),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .array_load_en(array_load_en),
    .array_load_row(array_load_row)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: the last accepted command and pending pulses, in cycles.
  bit m_act    = 1'b0;
  int m_t      = 0;
  int m_b      = 0;
  int m_r      = 0;
  int m_err_at = -1;
  int m_zd_at  = -1;
  int m_raddr  = 0;
  bit m_busy   = 1'b0;

  int n_load = 0;
  int n_err  = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare every output against what the timing rules predict for this cycle.
  task automatic check_outputs();
    int c;
    bit issue;
    bit ld;
    bit ready;
    bit we;
    bit done;
    bit err;
    int raddr;
    c     = cyc;
    m_busy = m_act && (c >= m_t + 1) && (c <= m_t + m_r + 1);
    issue = m_act && (c >= m_t + 1) && (c <= m_t + m_r);
    ld    = m_act && (c >= m_t + 2) && (c <= m_t + m_r + 1);
    raddr = issue ? (m_b + ARRAY_DIM * (c - m_t - 1)) : m_raddr;
    ready = !m_busy && !fetch_start;
    we    = ready && host_wr_valid && (int'(host_wr_addr) < MEM_DEPTH);
    done  = (m_act && (c == m_t + m_r + 1)) || (c == m_zd_at);
    err   = (c == m_err_at);
    chk("busy", 32'(fetch_busy), 32'(m_busy));
    chk("ready", 32'(host_wr_ready), 32'(ready));
    chk("mem_we", 32'(mem_we), 32'(we));
    if (we) begin
      chk("waddr", 32'(mem_waddr), 32'(host_wr_addr));
      chk("wdata", 32'(mem_wdata), 32'(host_wr_data));
    end
    chk("raddr", 32'(mem_raddr), 32'(raddr & 32'h1FFF));
    chk("load_en", 32'(array_load_en), 32'(ld));
    if (ld) chk("load_row", 32'(array_load_row), 32'(c - m_t - 2));
    chk("done", 32'(fetch_done), 32'(done));
    chk("err", 32'(fetch_err), 32'(err));
    m_raddr = raddr;
    n_load += int'(array_load_en);
    n_err  += int'(fetch_err);
    n_done += int'(fetch_done);
  endtask

  // Model reaction to the accept edge closing the current cycle.
  task automatic model_edge();
    if (!m_busy && fetch_start) begin
      if (fetch_rows == 3'd0) begin
        m_zd_at = cyc + 1;
      end else if ((fetch_rows > 3'(MAX_ROWS)) ||
                   (int'(fetch_base) + ARRAY_DIM * int'(fetch_rows) > MEM_DEPTH)) begin
        m_err_at = cyc + 1;
      end else begin
        m_act = 1'b1;
        m_t   = cyc;
        m_b   = int'(fetch_base);
        m_r   = int'(fetch_rows);
      end
    end
    cyc++;
  endtask

  task automatic step(input logic fs, input logic [ADDR_W-1:0] fb, input logic [2:0] fr,
                      input logic hv, input logic [ADDR_W-1:0] ha, input logic [7:0] hd);
    fetch_start   = fs;
    fetch_base    = fb;
    fetch_rows    = fr;
    host_wr_valid = hv;
    host_wr_addr  = ha;
    host_wr_data  = hd;
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 3'd0, 1'b0, '0, 8'd0);
  endtask

  // Asynchronous reset asserted just after an edge; outputs must clear at once.
  task automatic apply_reset();
    fetch_start   = 1'b0;
    host_wr_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_ready", 32'(host_wr_ready), 32'd1);
    chk("rst_done", 32'(fetch_done), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_load_en", 32'(array_load_en), 32'd0);
    chk("rst_load_row", 32'(array_load_row), 32'd0);
    m_act = 1'b0; m_err_at = -1; m_zd_at = -1; m_raddr = 0; m_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc += 2;
  endtask

  typedef struct {
    logic              fs;
    logic              hv;
    logic [ADDR_W-1:0] ha;
    logic [7:0]        hd;
    logic              exp_ready;
    logic              exp_we;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [2:0]        rows;
    int                exp_loads;
    int                exp_err;
    int                exp_done;
  } cmd_t;

  vec_t vecs[6];
  cmd_t cmds[9];

  initial begin
    reset = 1'b1; fetch_start = 1'b0; fetch_base = '0; fetch_rows = 3'd0;
    host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = 8'd0;

    vecs[0] = '{1'b0, 1'b1, 13'd5,  8'h11, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 13'd31, 8'h22, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 13'd32, 8'h33, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 13'd4,  8'h44, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 13'd6,  8'h55, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 13'd40, 8'h66, 1'b1, 1'b0};

    cmds[0] = '{13'd0,    3'd4, 4, 0, 1};
    cmds[1] = '{13'd28,   3'd2, 0, 1, 0};
    cmds[2] = '{13'd0,    3'd5, 0, 1, 0};
    cmds[3] = '{13'd8,    3'd0, 0, 0, 1};
    cmds[4] = '{13'd28,   3'd1, 1, 0, 1};
    cmds[5] = '{13'd16,   3'd3, 3, 0, 1};
    cmds[6] = '{13'd30,   3'd1, 0, 1, 0};
    cmds[7] = '{13'd0,    3'd7, 0, 1, 0};
    cmds[8] = '{13'd8191, 3'd1, 0, 1, 0};

    @(posedge clk);
    #1;
    apply_reset();

    // Host preload 0x01..0x10 into addresses 0..15, then a full 4-row tile.
    for (int i = 0; i < 16; i++) step(1'b0, '0, 3'd0, 1'b1, 13'(i), 8'(i + 1));
    n_load = 0; n_done = 0;
    step(1'b1, 13'd0, 3'd4, 1'b0, '0, 8'd0);
    idle(6);
    chk("t1_loads", 32'(n_load), 32'd4);
    chk("t1_done", 32'(n_done), 32'd1);

    // Idle-state handshake vectors (fetch_start vectors carry rows=0).
    for (int i = 0; i < 6; i++) begin
      fetch_start = vecs[i].fs; fetch_base = '0; fetch_rows = 3'd0;
      host_wr_valid = vecs[i].hv; host_wr_addr = vecs[i].ha; host_wr_data = vecs[i].hd;
      #1;
      chk("vec_ready", 32'(host_wr_ready), 32'(vecs[i].exp_ready));
      chk("vec_we", 32'(mem_we), 32'(vecs[i].exp_we));
      step(vecs[i].fs, '0, 3'd0, vecs[i].hv, vecs[i].ha, vecs[i].hd);
    end
    idle(2);

    // Command table: count loads, errors and done pulses per command.
    for (int i = 0; i < 9; i++) begin
      n_load = 0; n_err = 0; n_done = 0;
      step(1'b1, cmds[i].base, cmds[i].rows, 1'b0, '0, 8'd0);
      idle(7);
      chk("cmd_loads", 32'(n_load), 32'(cmds[i].exp_loads));
      chk("cmd_err", 32'(n_err), 32'(cmds[i].exp_err));
      chk("cmd_done", 32'(n_done), 32'(cmds[i].exp_done));
    end

    // Tie between fetch and host: host stalls until the fetch finishes.
    step(1'b1, 13'd4, 3'd2, 1'b1, 13'd3, 8'hAA);
    for (int i = 0; i < 4; i++) step(1'b0, 13'd0, 3'd0, 1'b1, 13'd3, 8'hAA);
    idle(2);

    // Reset in cycle T+2 of a 4-row fetch, then a clean 1-row fetch.
    step(1'b1, 13'd0, 3'd4, 1'b0, '0, 8'd0);
    step(1'b0, 13'd0, 3'd0, 1'b0, '0, 8'd0);
    n_done = 0; n_load = 0;
    apply_reset();
    idle(6);
    chk("t4_no_done", 32'(n_done), 32'd0);
    chk("t4_no_load", 32'(n_load), 32'd0);
    step(1'b1, 13'd16, 3'd1, 1'b0, '0, 8'd0);
    idle(4);
    chk("t4_loads", 32'(n_load), 32'd1);
    chk("t4_done", 32'(n_done), 32'd1);

    // Restrobe while busy and move fetch_base mid-command.
    n_load = 0; n_done = 0;
    step(1'b1, 13'd8, 3'd3, 1'b0, '0, 8'd0);
    step(1'b1, 13'd20, 3'd2, 1'b0, '0, 8'd0);
    step(1'b0, 13'd24, 3'd1, 1'b0, '0, 8'd0);
    step(1'b1, 13'd0, 3'd4, 1'b0, '0, 8'd0);
    step(1'b0, 13'd4, 3'd4, 1'b0, '0, 8'd0);
    idle(4);
    chk("t5_loads", 32'(n_load), 32'd3);
    chk("t5_done", 32'(n_done), 32'd1);

    // Out-of-range host write is accepted and dropped.
    n_err = 0;
    step(1'b0, '0, 3'd0, 1'b1, 13'd40, 8'h5A);
    idle(2);
    chk("t6_err", 32'(n_err), 32'd0);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        step(($urandom_range(0, 5) == 0),
             13'($urandom_range(0, 34)),
             3'($urandom_range(0, 6)),
             1'($urandom_range(0, 1)),
             13'($urandom_range(0, 47)),
             8'($urandom_range(0, 255)));
      end
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
